// File: rtl/wallace_seq_mult_pkg.sv
// rtl/wallace_seq_mult_pkg.sv - shared state encodings, widths and the full-adder cell
package wallace_seq_mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACCUM   = 2'd1;
  localparam state_t ST_RESOLVE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  localparam int unsigned N_DEFAULT = 8;

  function automatic int unsigned prod_w(input int unsigned n);
    return 2 * n;
  endfunction

  // Returns {carry, sum}; shared by the carry-save row and the resolve ripple chain.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

endpackage

// File: rtl/wallace_seq_mult_csa_row.sv
// rtl/wallace_seq_mult_csa_row.sv - W-wide row of full adders, carry output unshifted
module csa_row
  import wallace_seq_mult_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] z_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign {carry_o[i], sum_o[i]} = fa(x_i[i], y_i[i], z_i[i]);
  end

endmodule

// File: rtl/wallace_seq_mult.sv
// rtl/wallace_seq_mult.sv - iterative unsigned NxN multiplier: one carry-save row per
// multiplier bit, then a single ripple-carry resolve, valid/ready on both sides.
module wallace_seq_mult
  import wallace_seq_mult_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [N-1:0]           a_i,
  input  logic [N-1:0]           b_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [prod_w(N)-1:0]   p_o,
  output logic                   busy_o
);

  localparam int unsigned W  = prod_w(N);
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [N-1:0]    a_q, b_q;
  logic [W-1:0]    s_q, c_q, p_q;
  logic [W-1:0]    pp, csa_sum, csa_carry, csa_shl, rsum;
  logic            rc;

  assign pp = W'(a_q & {N{b_q[count_q]}}) << count_q;

  csa_row #(.W(W)) u_csa_row (
    .x_i    (s_q),
    .y_i    (c_q),
    .z_i    (pp),
    .sum_o  (csa_sum),
    .carry_o(csa_carry)
  );

  // The true product fits in W bits, so the carry shifted out of the top is always zero.
  always_comb begin
    csa_shl = csa_carry << 1;
  end

  always_comb begin
    rc   = 1'b0;
    rsum = '0;
    for (int i = 0; i < W; i++) begin
      {rc, rsum[i]} = fa(s_q[i], c_q[i], rc);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (in_valid_i)       state_d = ST_ACCUM;
      ST_ACCUM:   if (count_q == LAST)  state_d = ST_RESOLVE;
      ST_RESOLVE:                       state_d = ST_DONE;
      ST_DONE:    if (out_ready_i)      state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    busy_o      = (state_q == ST_ACCUM) || (state_q == ST_RESOLVE);
    out_valid_o = (state_q == ST_DONE);
    p_o         = p_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      p_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            s_q     <= '0;
            c_q     <= '0;
            count_q <= '0;
          end
        end
        ST_ACCUM: begin
          s_q <= csa_sum;
          c_q <= csa_shl;
          if (count_q != LAST) begin
            count_q <= count_q + 1'b1;
          end
        end
        ST_RESOLVE: p_q <= rsum;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wallace_seq_mult.sv
// tb/tb_wallace_seq_mult.sv - randomized and directed self-checking bench for wallace_seq_mult
module tb_wallace_seq_mult;

  localparam int N = 8;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] p;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  int produced = 0;

  always #5 clk = ~clk;

  wallace_seq_mult #(.N(N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .p_o        (p),
    .busy_o     (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_p"}, 64'(p), 64'd0);
  endtask

  // One full transaction: offer operands, track latency, apply output stall, handshake.
  task automatic run_txn(input logic [N-1:0] ta, input logic [N-1:0] tb, input int stall,
                         input bit intrude, input bit rand_ready);
    int          lat;
    int          waited;
    int          bad;
    logic [W-1:0] held;
    logic [W-1:0] expected;
    expected = W'(ta) * W'(tb);
    @(negedge clk);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    accepted++;
    a = N'($urandom);
    b = N'($urandom);
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 40) begin
      if (!busy || in_ready) bad++;
      if (intrude && lat == 2) begin
        in_valid = 1'b1;
        a = 3;
        b = 3;
      end
      if (lat == 5) in_valid = 1'b0;
      if (rand_ready) out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", 64'(lat), 64'(N + 1));
    check("busy_while_computing", 64'(bad), 64'd0);
    if (out_valid) produced++;
    check("product", 64'(p), 64'(expected));
    check("busy_in_done", 64'(busy), 64'd0);
    held = p;
    bad = 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || p !== held) bad++;
    end
    check("stall_hold", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", 64'(out_valid), 64'd0);
    check("in_ready_after_hs", 64'(in_ready), 64'd1);
    check("p_retained", 64'(p), 64'(expected));
  endtask

  initial begin
    int seen_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_txn(8'd13, 8'd11, 0, 1'b0, 1'b0);
    run_txn(8'd255, 8'd255, 0, 1'b0, 1'b0);
    run_txn(8'd0, 8'd200, 0, 1'b0, 1'b0);
    run_txn(8'd1, 8'd128, 0, 1'b0, 1'b0);
    run_txn(8'd7, 8'd9, 5, 1'b0, 1'b0);
    run_txn(8'd20, 8'd10, 1, 1'b1, 1'b1);
    run_txn(8'd255, 8'd1, 0, 1'b0, 1'b0);

    // Reset during the fourth ACCUM cycle of 100 x 50.
    @(negedge clk);
    a = 8'd100;
    b = 8'd50;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    check("no_spurious_valid", 64'(seen_valid), 64'd0);
    run_txn(8'd5, 8'd6, 0, 1'b0, 1'b0);

    accepted = 0;
    produced = 0;
    for (int t = 0; t < 3000; t++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      run_txn(N'($urandom), N'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'b1);
    end
    check("one_result_per_accept", 64'(produced), 64'(accepted));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
